// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: segment arithmetic, width sanity check and the
// per-byte data/keep bundle used to build packed segments.
package axis_pkg;

   // One byte of stream payload with its byte enable; a segment is
   // S_KEEP_WIDTH of these, an output word M_KEEP_WIDTH of these.
   typedef struct packed {
      logic [7:0] data;
      logic       keep;
   } lane_t;

   // Number of narrow segments that make up one wide word.
   function automatic int seg_count(input int s, input int m);
      return m / s;
   endfunction

   // Widths are legal when both are byte multiples and m is at least 2x s.
   function automatic bit widths_ok(input int s, input int m);
      return (s > 0) && (s % 8 == 0) && (m % s == 0) && (m / s >= 2);
   endfunction

endpackage

// File: rtl/axis_upsizer_out_reg.sv
// Valid/ready holding register: loads a word, holds it while the consumer
// stalls, drops valid when drained with nothing new to load.
module axis_upsizer_out_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             free
);

   // Register may take a new word when empty or being drained this cycle.
   assign free = !out_valid || out_ready;

   // Load has priority over drain so back-to-back words leave no valid gap;
   // the producer only asserts load while free is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_upsizer.sv
// AXI4-Stream width upsizer: packs SEG_COUNT narrow beats into one wide beat,
// first beat in the lowest segment; tlast closes a partial word early.
// Optional status counters are enabled with `define AXIS_UPSIZER_STATS_EN.
module axis_upsizer
   import axis_pkg::*;
#(
   parameter int S_DATA_WIDTH = 8,
   parameter int M_DATA_WIDTH = 32,
   parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
   parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
   parameter int USER_WIDTH   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [USER_WIDTH-1:0]   m_axis_tuser
`ifdef AXIS_UPSIZER_STATS_EN
   ,
   output logic [31:0]             status_frame_count,
   output logic [31:0]             status_word_count
`endif
);

   localparam int SEG_COUNT = seg_count(S_DATA_WIDTH, M_DATA_WIDTH);
   localparam int SEG_W     = $clog2(SEG_COUNT);
   localparam int OW        = M_DATA_WIDTH + M_KEEP_WIDTH + USER_WIDTH + 1;

   if (!widths_ok(S_DATA_WIDTH, M_DATA_WIDTH)) begin : g_bad_width
      $error("axis_upsizer: M_DATA_WIDTH must be a >=2x multiple of S_DATA_WIDTH");
   end

   lane_t [M_KEEP_WIDTH-1:0] acc_lane;
   lane_t [M_KEEP_WIDTH-1:0] mrg_lane;
   logic [M_DATA_WIDTH-1:0]  acc_data, mrg_data;
   logic [M_KEEP_WIDTH-1:0]  acc_keep, mrg_keep;
   logic [USER_WIDTH-1:0]    acc_user, mrg_user;
   logic                     acc_last, acc_done;
   logic [SEG_W-1:0]         seg_cnt;
   logic                     accept, completing, out_free, out_load;
   logic [OW-1:0]            word_new, word_held, out_word;

   // Byte lane j belongs to segment j/S_KEEP_WIDTH; the active segment takes
   // the incoming beat, every other lane keeps its accumulated value (which
   // is zero above seg_cnt because the accumulator is cleared per word).
   for (genvar j = 0; j < M_KEEP_WIDTH; j++) begin : g_lane
      assign mrg_lane[j] = (seg_cnt == SEG_W'(j / S_KEEP_WIDTH))
                         ? lane_t'{data: s_axis_tdata[(j % S_KEEP_WIDTH)*8 +: 8],
                                   keep: s_axis_tkeep[j % S_KEEP_WIDTH]}
                         : acc_lane[j];
      assign mrg_data[j*8 +: 8] = mrg_lane[j].data;
      assign mrg_keep[j]        = mrg_lane[j].keep;
      assign acc_data[j*8 +: 8] = acc_lane[j].data;
      assign acc_keep[j]        = acc_lane[j].keep;
   end

   assign s_axis_tready = !acc_done;
   assign accept        = s_axis_tvalid && !acc_done;
   assign completing    = accept && (s_axis_tlast || seg_cnt == SEG_W'(SEG_COUNT - 1));
   assign mrg_user      = acc_user | s_axis_tuser;
   assign word_new      = {mrg_data, mrg_keep, mrg_user, s_axis_tlast};
   assign word_held     = {acc_data, acc_keep, acc_user, acc_last};
   // A held word and a new completing beat are exclusive: acc_done blocks input.
   assign out_load      = out_free && (acc_done || completing);

   axis_upsizer_out_reg #(.WIDTH(OW)) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (out_load),
      .load_data (acc_done ? word_held : word_new),
      .out_data  (out_word),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .free      (out_free)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_word;

   // Accumulate beats; park a finished word in the accumulator (acc_done)
   // only when the output register is busy, otherwise it bypasses straight out.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_cnt  <= '0;
         acc_done <= 1'b0;
         acc_lane <= '0;
         acc_user <= '0;
         acc_last <= 1'b0;
      end else if (acc_done) begin
         if (out_free) begin
            acc_done <= 1'b0;
            acc_lane <= '0;
            acc_user <= '0;
            acc_last <= 1'b0;
         end
      end else if (accept) begin
         if (completing) begin
            seg_cnt <= '0;
            if (out_free) begin
               acc_lane <= '0;
               acc_user <= '0;
               acc_last <= 1'b0;
            end else begin
               acc_lane <= mrg_lane;
               acc_user <= mrg_user;
               acc_last <= s_axis_tlast;
               acc_done <= 1'b1;
            end
         end else begin
            seg_cnt  <= seg_cnt + 1'b1;
            acc_lane <= mrg_lane;
            acc_user <= mrg_user;
         end
      end
   end

`ifdef AXIS_UPSIZER_STATS_EN
   // Count output handshakes: every word, and frames on the tlast word.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_frame_count <= '0;
         status_word_count  <= '0;
      end else if (m_axis_tvalid && m_axis_tready) begin
         status_word_count <= status_word_count + 32'd1;
         if (m_axis_tlast) status_frame_count <= status_frame_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer (S=8, M=32): directed frames with
// literal expectations plus randomized traffic against a queue-based model.
module tb_axis_upsizer;

   localparam int SW  = 8;
   localparam int MW  = 32;
   localparam int SK  = SW / 8;
   localparam int MK  = MW / 8;
   localparam int UW  = 1;
   localparam int SEG = MW / SW;
   localparam int OW  = MW + MK + UW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] s_tdata;
   logic [SK-1:0] s_tkeep;
   logic          s_tvalid, s_tready, s_tlast;
   logic [UW-1:0] s_tuser;
   logic [MW-1:0] m_tdata;
   logic [MK-1:0] m_tkeep;
   logic          m_tvalid, m_tready, m_tlast;
   logic [UW-1:0] m_tuser;
`ifdef AXIS_UPSIZER_STATS_EN
   logic [31:0]   frame_cnt, word_cnt;
`endif

   axis_upsizer #(.S_DATA_WIDTH(SW), .M_DATA_WIDTH(MW), .USER_WIDTH(UW)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
`ifdef AXIS_UPSIZER_STATS_EN
      , .status_frame_count(frame_cnt), .status_word_count(word_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, tready_low = 0;
   bit rnd = 0;

   logic [OW-1:0] log_q[$];
   logic [OW-1:0] exp_q[$];
   logic [SW-1:0] bd[$];
   logic [SK-1:0] bk[$];
   logic [UW-1:0] bu[$];
   logic          pv_stall = 0;
   logic [OW-1:0] pv_word;

   function automatic logic [OW-1:0] mkw(logic [MW-1:0] d, logic [MK-1:0] k,
                                         logic [UW-1:0] u, logic l);
      return {d, k, u, l};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model + compare: each accepted beat goes into a list; a word is formed
   // from the list when SEG beats are present or tlast arrives. Every output
   // handshake must match the oldest pending word.
   always @(negedge clk) begin
      if (rst) begin
         bd.delete(); bk.delete(); bu.delete(); exp_q.delete();
         pv_stall = 0;
      end else begin
         if (pv_stall)
            chk("hold_stable", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'(pv_word));
         if (!s_tready) tready_low++;
         if (m_tvalid && m_tready) begin
            log_q.push_back({m_tdata, m_tkeep, m_tuser, m_tlast});
            if (exp_q.size() == 0)
               chk("unexpected_word", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'hDEAD);
            else
               chk("model_word", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'(exp_q.pop_front()));
         end
         if (s_tvalid && s_tready) begin
            bd.push_back(s_tdata); bk.push_back(s_tkeep); bu.push_back(s_tuser);
            if (bd.size() == SEG || s_tlast) begin
               logic [MW-1:0] d; logic [MK-1:0] k; logic [UW-1:0] u;
               d = '0; k = '0; u = '0;
               for (int i = 0; i < bd.size(); i++) begin
                  d[i*SW +: SW] = bd[i];
                  k[i*SK +: SK] = bk[i];
                  u = u | bu[i];
               end
               exp_q.push_back(mkw(d, k, u, s_tlast));
               bd.delete(); bk.delete(); bu.delete();
            end
         end
         pv_stall = m_tvalid && !m_tready;
         pv_word  = {m_tdata, m_tkeep, m_tuser, m_tlast};
      end
   end

   // Random downstream backpressure while the random phase runs.
   initial forever begin
      @(posedge clk); #1;
      if (rnd) m_tready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(logic [SW-1:0] d, logic [SK-1:0] k, logic l, logic [UW-1:0] u);
      int n; bit ok;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1; n = 0;
      forever begin
         @(negedge clk); ok = s_tready;
         @(posedge clk); #1;
         if (ok) break;
         n++;
         if (n > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got stalled %0d cycles, required accept", n);
            break;
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(logic [7:0] base, int len);
      for (int i = 0; i < len; i++) send(base + 8'(i), 1'b1, i == len - 1, 1'b0);
   endtask

   initial begin
      int b, t0;
      rst = 1; s_tvalid = 0; s_tdata = 0; s_tkeep = 0; s_tlast = 0; s_tuser = 0; m_tready = 1;
      @(posedge clk); #1;
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_out", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'd0);
      chk("rst_tready", 64'(s_tready), 64'd1);
      rst = 0;
      idle(1);

      // 4-beat frame: word appears one cycle after the last beat
      t0 = tready_low;
      send(8'h11, 1, 0, 0); send(8'h22, 1, 0, 0); send(8'h33, 1, 0, 0); send(8'h44, 1, 1, 0);
      chk("t1_valid", 64'(m_tvalid), 64'd1);
      chk("t1_word", 64'({m_tdata, m_tkeep, m_tuser, m_tlast}), 64'(mkw(32'h44332211, 4'hF, 0, 1)));
      idle(2);
      chk("t1_tready_low", 64'(tready_low - t0), 64'd0);

      // 6-byte frame: full word then partial word with upper keep cleared
      b = log_q.size();
      frame(8'hA0, 6);
      idle(3);
      chk("t2_count", 64'(log_q.size() - b), 64'd2);
      chk("t2_w0", 64'(log_q[b]), 64'(mkw(32'hA3A2A1A0, 4'hF, 0, 0)));
      chk("t2_w1", 64'(log_q[b+1]), 64'(mkw(32'h0000A5A4, 4'h3, 0, 1)));

      // Backpressure: second word parks, input stalls after 8th byte
      b = log_q.size();
      m_tready = 0;
      for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i), 1, 0, 0);
      chk("t3_stall", 64'(s_tready), 64'd0);
      chk("t3_held", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'hB3B2B1B0}));
      fork
         for (int i = 8; i < 12; i++) send(8'hB0 + 8'(i), 1, i == 11, 0);
         begin
            idle(3);
            chk("t3_still_stall", 64'(s_tready), 64'd0);
            chk("t3_still_held", 64'(m_tdata), 64'h B3B2B1B0);
            m_tready = 1;
         end
      join
      idle(4);
      chk("t3_count", 64'(log_q.size() - b), 64'd3);
      chk("t3_w0", 64'(log_q[b]), 64'(mkw(32'hB3B2B1B0, 4'hF, 0, 0)));
      chk("t3_w1", 64'(log_q[b+1]), 64'(mkw(32'hB7B6B5B4, 4'hF, 0, 0)));
      chk("t3_w2", 64'(log_q[b+2]), 64'(mkw(32'hBBBAB9B8, 4'hF, 0, 1)));

      // tuser OR only affects the word it arrived in
      b = log_q.size();
      for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1, i == 7, 1'(i == 1));
      idle(3);
      chk("t4_user0", 64'(log_q[b][1]), 64'd1);
      chk("t4_user1", 64'(log_q[b+1][1]), 64'd0);

      // Reset mid-frame discards the partial word
      send(8'hE0, 1, 0, 0); send(8'hE1, 1, 0, 0);
      b = log_q.size();
      rst = 1; idle(1);
      chk("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
      rst = 0;
      frame(8'h01, 4);
      idle(3);
      chk("t5_count", 64'(log_q.size() - b), 64'd1);
      chk("t5_word", 64'(log_q[b]), 64'(mkw(32'h04030201, 4'hF, 0, 1)));

`ifdef AXIS_UPSIZER_STATS_EN
      rst = 1; idle(1); rst = 0;
      chk("st_rst", 64'({frame_cnt, word_cnt}), 64'd0);
      frame(8'h10, 6); frame(8'h20, 6); frame(8'h30, 6);
      idle(3);
      chk("st_frames", 64'(frame_cnt), 64'd3);
      chk("st_words", 64'(word_cnt), 64'd6);
`endif

      // Randomized traffic with random gaps and backpressure
      rnd = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         send(8'($urandom), 1'($urandom), (i == 399) || ($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 7) == 0));
      end
      rnd = 0;
      idle(1);
      m_tready = 1;
      idle(10);
      chk("rnd_drained", 64'(exp_q.size()), 64'd0);
      chk("rnd_valid_low", 64'(m_tvalid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
